fft_frame_ctrl: RTL and testbench

Sequencer in front of and behind the FFT core. After enable, it sends one configuration word to the FFT config channel. It then frames free-running 12-bit ADC samples into NFFT-sample AXI-stream frames with tlast, and converts offset-binary samples to signed. On the output side it walks the amplitude stream and reports the peak bin per frame.

---
 rtl/fft_frame_ctrl_pkg.sv | 26 ++
 rtl/fft_frame_ctrl_if.sv | 51 +++++
 rtl/fft_frame_ctrl_peak_tracker.sv | 86 ++++++++
 rtl/fft_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_fft_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and constants for the FFT frame controller.
// Holds the FSM encoding, the default config word and the sample conversion.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        RUN
    } state_e;

    localparam logic [15:0] CFG_WORD_DEF = 16'h0001;
    localparam int          ADC_W_DEF    = 12;
    localparam int          AMP_W_DEF    = 43;
    localparam int          DAT_W        = 16;
    localparam int          CFG_W        = 16;

    // Offset-binary ADC code to two's complement, sign-extended.
    function automatic logic [DAT_W-1:0] off2sgn(
        input logic [ADC_W_DEF-1:0] s
    );
        logic [ADC_W_DEF-1:0] f;
        f = {~s[ADC_W_DEF-1], s[ADC_W_DEF-2:0]};
        return {{(DAT_W-ADC_W_DEF){f[ADC_W_DEF-1]}}, f};
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Bus bundle between the frame controller and its surroundings.
// slave is the controller side, master the ADC/FFT side.
interface fft_frame_ctrl_if
    import fft_ctrl_pkg::*;
#(
    parameter int NFFT_LOG2 = 10,
    parameter int ADC_W     = ADC_W_DEF,
    parameter int AMP_W     = AMP_W_DEF
);

    logic                 enable;
    logic [ADC_W-1:0]     adc_data;
    logic                 adc_valid;
    logic [CFG_W-1:0]     cfg_tdata;
    logic                 cfg_tvalid;
    logic                 cfg_tready;
    logic [31:0]          dat_tdata;
    logic                 dat_tvalid;
    logic                 dat_tlast;
    logic                 dat_tready;
    logic [AMP_W-1:0]     fft_amp;
    logic                 fft_out_valid;
    logic                 fft_out_last;
    logic [NFFT_LOG2-1:0] peak_bin;
    logic [AMP_W-1:0]     peak_amp;
    logic                 frame_done;
    logic                 overrun;
    logic                 last_err;
    logic                 busy;

    modport slave (
        input  enable, adc_data, adc_valid,
        input  cfg_tready, dat_tready,
        input  fft_amp, fft_out_valid, fft_out_last,
        output cfg_tdata, cfg_tvalid,
        output dat_tdata, dat_tvalid, dat_tlast,
        output peak_bin, peak_amp, frame_done,
        output overrun, last_err, busy
    );

    modport master (
        output enable, adc_data, adc_valid,
        output cfg_tready, dat_tready,
        output fft_amp, fft_out_valid, fft_out_last,
        input  cfg_tdata, cfg_tvalid,
        input  dat_tdata, dat_tvalid, dat_tlast,
        input  peak_bin, peak_amp, frame_done,
        input  overrun, last_err, busy
    );

endinterface

// File: rtl/fft_frame_ctrl_peak_tracker.sv
// Output-side bin counter and per-frame peak search.
// Runs independently of the input FSM; lowest index wins on ties.
module fft_peak_tracker
    import fft_ctrl_pkg::*;
#(
    parameter int NFFT_LOG2 = 10,
    parameter int AMP_W     = AMP_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AMP_W-1:0]     amp_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    input  logic                 clr_err_i,
    output logic [NFFT_LOG2-1:0] peak_bin_o,
    output logic [AMP_W-1:0]     peak_amp_o,
    output logic                 frame_done_o,
    output logic                 last_err_o
);

    localparam logic [NFFT_LOG2-1:0] LAST = '1;

    logic [NFFT_LOG2-1:0] bin_q, bin_d;
    logic [NFFT_LOG2-1:0] arg_q, arg_d;
    logic [AMP_W-1:0]     max_q, max_d;
    logic [NFFT_LOG2-1:0] pbin_q, pbin_d;
    logic [AMP_W-1:0]     pamp_q, pamp_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    // Running max per frame, published when the last bin goes by.
    always_comb begin
        bin_d  = bin_q;
        arg_d  = arg_q;
        max_d  = max_q;
        pbin_d = pbin_q;
        pamp_d = pamp_q;
        done_d = 1'b0;
        err_d  = err_q;
        if (clr_err_i) begin
            err_d = 1'b0;
        end
        if (valid_i) begin
            bin_d = bin_q + 1'b1;
            if ((bin_q == '0) || (amp_i > max_q)) begin
                max_d = amp_i;
                arg_d = bin_q;
            end
            if (last_i != (bin_q == LAST)) begin
                err_d = 1'b1;
            end
            if (bin_q == LAST) begin
                pbin_d = arg_d;
                pamp_d = max_d;
                done_d = 1'b1;
            end
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            arg_q  <= '0;
            max_q  <= '0;
            pbin_q <= '0;
            pamp_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            arg_q  <= arg_d;
            max_q  <= max_d;
            pbin_q <= pbin_d;
            pamp_q <= pamp_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign peak_bin_o   = pbin_q;
    assign peak_amp_o   = pamp_q;
    assign frame_done_o = done_q;
    assign last_err_o   = err_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT front/back sequencer: config handshake, ADC framing, peak report.
// Input side is a one-entry hold register feeding N-sample frames.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int          NFFT_LOG2 = 10,
    parameter int          ADC_W     = ADC_W_DEF,
    parameter int          AMP_W     = AMP_W_DEF,
    parameter logic [15:0] CFG_WORD  = CFG_WORD_DEF
) (
    input  logic            aclk,
    input  logic            arst,
    fft_frame_ctrl_if.slave bus
);

    localparam logic [NFFT_LOG2-1:0] LAST = '1;

    state_e               state_q, state_d;
    logic [NFFT_LOG2-1:0] in_cnt_q, in_cnt_d;
    logic [ADC_W-1:0]     hold_q, hold_d;
    logic                 full_q, full_d;
    logic                 ovr_q, ovr_d;

    logic xfer;
    logic frame_end;
    logic stop;
    logic load_en;
    logic cfg_entry;

    assign xfer      = full_q & bus.dat_tready;
    assign frame_end = xfer & (in_cnt_q == LAST);
    assign stop      = (state_q == RUN) & ~bus.enable
                     & (in_cnt_q == '0) & ~full_q;

    // Next state; only a clean frame boundary may return to IDLE.
    always_comb begin
        state_d   = state_q;
        cfg_entry = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d   = CFG;
                    cfg_entry = 1'b1;
                end
            end
            CFG: begin
                if (bus.cfg_tready) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold register, frame counter and overrun flag.
    // When stopping, no sample is taken on the closing transfer so the
    // controller lands on an empty boundary instead of opening a new frame.
    always_comb begin
        hold_d   = hold_q;
        full_d   = full_q;
        in_cnt_d = in_cnt_q;
        ovr_d    = ovr_q;
        load_en  = (state_q == RUN) & ~stop & ~(frame_end & ~bus.enable);
        if (cfg_entry) begin
            ovr_d = 1'b0;
        end
        if (xfer) begin
            full_d   = 1'b0;
            in_cnt_d = in_cnt_q + 1'b1;
        end
        if (load_en & bus.adc_valid) begin
            if (!full_q || xfer) begin
                hold_d = bus.adc_data;
                full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Input-side state registers.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            in_cnt_q <= '0;
            hold_q   <= '0;
            full_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.cfg_tvalid = (state_q == CFG);
    assign bus.cfg_tdata  = (state_q == CFG) ? CFG_WORD : '0;
    assign bus.dat_tvalid = full_q;
    assign bus.dat_tdata  = full_q ? {16'h0000, off2sgn(hold_q)} : '0;
    assign bus.dat_tlast  = full_q & (in_cnt_q == LAST);
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q != IDLE) | full_q;

    fft_peak_tracker #(
        .NFFT_LOG2 (NFFT_LOG2),
        .AMP_W     (AMP_W)
    ) u_peak (
        .clk_i        (aclk),
        .rst_i        (arst),
        .amp_i        (bus.fft_amp),
        .valid_i      (bus.fft_out_valid),
        .last_i       (bus.fft_out_last),
        .clr_err_i    (cfg_entry),
        .peak_bin_o   (bus.peak_bin),
        .peak_amp_o   (bus.peak_amp),
        .frame_done_o (bus.frame_done),
        .last_err_o   (bus.last_err)
    );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl with N=8: directed tables plus a
// queue/array reference model checked on every cycle.
module tb_fft_frame_ctrl;

    localparam int LG = 3;
    localparam int N  = 8;
    localparam int AW = 43;

    logic aclk = 1'b0;
    logic arst = 1'b0;
    always #5 aclk = ~aclk;

    fft_frame_ctrl_if #(.NFFT_LOG2(LG), .ADC_W(12), .AMP_W(AW)) bus ();

    fft_frame_ctrl #(.NFFT_LOG2(LG)) dut (
        .aclk (aclk),
        .arst (arst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_CFG, M_RUN} mode_t;
    mode_t          m;
    logic [11:0]    q[$];
    int             cnt;
    bit             ovr;
    int             bin;
    logic [AW-1:0]  fr[N];
    bit             lerr;
    bit             done;
    int             pbin;
    logic [AW-1:0]  pamp;

    function automatic logic [15:0] ref_conv(input logic [11:0] a);
        int v;
        v = int'(a) - 2048;
        return 16'(v);
    endfunction

    task automatic model_reset();
        m = M_IDLE;
        q.delete();
        cnt = 0;
        ovr = 0;
        bin = 0;
        lerr = 0;
        done = 0;
        pbin = 0;
        pamp = '0;
        foreach (fr[i]) fr[i] = '0;
    endtask

    task automatic model_edge();
        bit en, xf, fin, clr;
        en = bus.enable;
        clr = 0;
        done = 0;
        case (m)
            M_IDLE: if (en) begin m = M_CFG; ovr = 0; clr = 1; end
            M_CFG:  if (bus.cfg_tready) m = M_RUN;
            default: begin
                if (!en && cnt == 0 && q.size() == 0) begin
                    m = M_IDLE;
                end else begin
                    xf = (q.size() == 1) && bus.dat_tready;
                    fin = xf && (cnt == N - 1);
                    if (xf) begin
                        void'(q.pop_front());
                        cnt = (cnt + 1) % N;
                    end
                    if (bus.adc_valid && !(fin && !en)) begin
                        if (q.size() == 0) q.push_back(bus.adc_data);
                        else ovr = 1;
                    end
                end
            end
        endcase
        if (clr) lerr = 0;
        if (bus.fft_out_valid) begin
            fr[bin] = bus.fft_amp;
            if (bus.fft_out_last != (bin == N - 1)) lerr = 1;
            if (bin == N - 1) begin
                pbin = 0;
                for (int i = 1; i < N; i++)
                    if (fr[i] > fr[pbin]) pbin = i;
                pamp = fr[pbin];
                done = 1;
            end
            bin = (bin + 1) % N;
        end
    endtask

    task automatic check_all();
        logic [31:0] etd;
        etd = (q.size() == 1) ? {16'h0000, ref_conv(q[0])} : 32'h0;
        chk("cfg_tvalid", bus.cfg_tvalid, m == M_CFG);
        chk("cfg_tdata", bus.cfg_tdata, (m == M_CFG) ? 16'h0001 : 16'h0);
        chk("dat_tvalid", bus.dat_tvalid, q.size() == 1);
        chk("dat_tdata", bus.dat_tdata, etd);
        chk("dat_tlast", bus.dat_tlast, q.size() == 1 && cnt == N - 1);
        chk("overrun", bus.overrun, ovr);
        chk("busy", bus.busy, m != M_IDLE || q.size() != 0);
        chk("frame_done", bus.frame_done, done);
        chk("peak_bin", bus.peak_bin, pbin);
        chk("peak_amp", bus.peak_amp, pamp);
        chk("last_err", bus.last_err, lerr);
    endtask

    task automatic tick();
        @(posedge aclk);
        if (!arst) model_edge();
        @(negedge aclk);
        check_all();
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_busy", bus.busy, 0);
        tick();
        arst = 1'b0;
    endtask

    // ---------------- tables ----------------
    typedef struct {
        logic [11:0] adc;
        logic [15:0] re;
    } cv_t;

    typedef struct {
        logic [0:7][AW-1:0] amps;
        int                 pb;
        logic [AW-1:0]      pk;
    } pk_t;

    cv_t cv[6];
    pk_t pv[4];

    int hs, nx;
    bit lastt;

    initial begin
        cv[0] = '{12'hFFF, 16'h07FF};
        cv[1] = '{12'h000, 16'hF800};
        cv[2] = '{12'h800, 16'h0000};
        cv[3] = '{12'h7FF, 16'hFFFF};
        cv[4] = '{12'h801, 16'h0001};
        cv[5] = '{12'h123, 16'hF923};
        pv[0].amps = '{5, 9, 2, 9, 0, 0, 0, 1};
        pv[0].pb = 1; pv[0].pk = 9;
        pv[1].amps = '{7, 7, 7, 7, 7, 7, 7, 7};
        pv[1].pb = 0; pv[1].pk = 7;
        pv[2].amps = '{0, 1, 2, 3, 4, 5, 6, 7};
        pv[2].pb = 7; pv[2].pk = 7;
        pv[3].amps = '{3, 3, 3, 3, 43'h7FF_FFFF_FFFF, 0,
                       43'h7FF_FFFF_FFFE, 1};
        pv[3].pb = 4; pv[3].pk = 43'h7FF_FFFF_FFFF;

        bus.enable = 0; bus.adc_data = '0; bus.adc_valid = 0;
        bus.cfg_tready = 0; bus.dat_tready = 0;
        bus.fft_amp = '0; bus.fft_out_valid = 0; bus.fft_out_last = 0;

        @(negedge aclk);
        do_reset();
        tick();

        // continuous full-scale stream, one config handshake
        bus.enable = 1; bus.cfg_tready = 1; bus.dat_tready = 1;
        bus.adc_valid = 1; bus.adc_data = 12'hFFF;
        hs = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.cfg_tvalid && bus.cfg_tready) hs++;
            tick();
        end
        chk("cfg_handshakes", hs, 1);

        // conversion table
        bus.adc_valid = 0;
        tick();
        tick();
        foreach (cv[i]) begin
            bus.adc_valid = 1;
            bus.adc_data = cv[i].adc;
            tick();
            bus.adc_valid = 0;
            chk("conv_tdata", bus.dat_tdata, {16'h0000, cv[i].re});
            tick();
        end

        // back-pressure: first sample held, later ones dropped
        bus.dat_tready = 0;
        for (int i = 1; i <= 3; i++) begin
            bus.adc_valid = 1;
            bus.adc_data = 12'(i * 256);
            tick();
        end
        chk("stall_overrun", bus.overrun, 1);
        chk("stall_held", bus.dat_tdata, 32'h0000_F900);
        bus.dat_tready = 1;
        for (int i = 0; i < 20; i++) tick();

        // peak table
        foreach (pv[k]) begin
            for (int b = 0; b < N; b++) begin
                bus.fft_out_valid = 1;
                bus.fft_amp = pv[k].amps[b];
                bus.fft_out_last = (b == N - 1);
                tick();
            end
            bus.fft_out_valid = 0;
            bus.fft_out_last = 0;
            chk("pk_done", bus.frame_done, 1);
            chk("pk_bin", bus.peak_bin, pv[k].pb);
            chk("pk_amp", bus.peak_amp, pv[k].pk);
            chk("pk_lerr", bus.last_err, 0);
            tick();
            chk("pk_done_pulse", bus.frame_done, 0);
        end

        // early tlast on bin 5
        for (int b = 0; b < N; b++) begin
            bus.fft_out_valid = 1;
            bus.fft_amp = 43'(b);
            bus.fft_out_last = (b == 5);
            tick();
        end
        bus.fft_out_valid = 0;
        bus.fft_out_last = 0;
        chk("early_last_err", bus.last_err, 1);

        // stop, error stays sticky, cleared on the next CFG entry
        bus.enable = 0;
        for (int i = 0; i < 40 && bus.busy; i++) tick();
        chk("stop_idle", bus.busy, 0);
        chk("sticky_lerr", bus.last_err, 1);
        bus.enable = 1;
        tick();
        chk("cfg_clr_lerr", bus.last_err, 0);
        chk("cfg_clr_ovr", bus.overrun, 0);

        // drop enable after 3 transfers
        for (int i = 0; i < 40 && !(m == M_RUN && cnt == 3); i++) tick();
        chk("reach_cnt3", cnt, 3);
        bus.enable = 0;
        nx = 0;
        lastt = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            if (bus.dat_tvalid && bus.dat_tready) begin
                nx++;
                lastt = bus.dat_tlast;
            end
            tick();
        end
        chk("drain_xfers", nx, 5);
        chk("drain_tlast", lastt, 1);
        chk("drain_idle", bus.busy, 0);

        // async reset mid-frame, then restart
        bus.enable = 1;
        for (int i = 0; i < 40 && !(m == M_RUN && cnt == 4); i++) tick();
        chk("reach_cnt4", cnt, 4);
        do_reset();
        hs = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.cfg_tvalid && bus.cfg_tready) hs++;
            tick();
        end
        chk("rst_cfg_handshake", hs, 1);

        // randomized traffic against the model
        for (int i = 0; i < 900; i++) begin
            bus.enable = ($urandom_range(0, 99) < 92);
            bus.cfg_tready = $urandom_range(0, 1);
            bus.dat_tready = ($urandom_range(0, 99) < 70);
            bus.adc_valid = ($urandom_range(0, 99) < 60);
            bus.adc_data = 12'($urandom);
            bus.fft_out_valid = ($urandom_range(0, 99) < 60);
            bus.fft_amp = ($urandom_range(0, 9) == 0) ?
                          43'({$urandom, $urandom}) :
                          43'($urandom_range(0, 15));
            bus.fft_out_last = (bin == N - 1) ^
                               ($urandom_range(0, 99) < 3);
            if (i % 300 == 299) do_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
